// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-cycle wide adder sequencing one 8-bit carry-select slice (optional WIDE_ADD_OVF_EN adds ovf)
module wide_add_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef WIDE_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N   = WIDTH / 8;
    localparam int K_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    // Operand registers shift right one byte per RUN cycle so the slice
    // always reads bits [7:0]; sum fills in from the top the same way.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef WIDE_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [4:0] lo_nib;
    logic [4:0] hi_nib0;
    logic [4:0] hi_nib1;
    logic [7:0] slice_sum;
    logic       slice_cout;
    logic       last_slice;

    // Carry-select slice: ripple low nibble, high nibble precomputed for both carries.
    always_comb begin
        lo_nib     = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
        hi_nib0    = {1'b0, a_q[7:4]} + {1'b0, b_q[7:4]};
        hi_nib1    = {1'b0, a_q[7:4]} + {1'b0, b_q[7:4]} + 5'd1;
        slice_sum  = {(lo_nib[4] ? hi_nib1[3:0] : hi_nib0[3:0]), lo_nib[3:0]};
        slice_cout = lo_nib[4] ? hi_nib1[4] : hi_nib0[4];
        last_slice = (k_q == K_W'(N - 1));
    end

    // Next-state and datapath update; everything holds unless a branch changes it.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef WIDE_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 8;
                b_d     = b_q >> 8;
                sum_d   = (sum_q >> 8) | (WIDTH'(slice_sum) << (WIDTH - 8));
                carry_d = slice_cout;
                k_d     = k_q + K_W'(1);
                if (last_slice) begin
                    k_d     = '0;
                    cout_d  = slice_cout;
`ifdef WIDE_ADD_OVF_EN
                    // Carry into the MSB is recovered as a7 ^ b7 ^ s7.
                    ovf_d   = a_q[7] ^ b_q[7] ^ slice_sum[7] ^ slice_cout;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef WIDE_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef WIDE_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - directed self-checking bench for wide_add_sequencer (WIDTH=32)
module tb_wide_add_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef WIDE_ADD_OVF_EN
    logic        ovf;
`endif

    int checks   = 0;
    int failures = 0;

    wide_add_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef WIDE_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands in IDLE and complete the input handshake.
    task automatic send(input string tag, input logic [31:0] ta, input logic [31:0] tb_op, input logic tc);
        @(negedge clk);
        a        = ta;
        b        = tb_op;
        cin      = tc;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from acceptance to out_valid; must be exactly 4.
    task automatic wait_out(input string tag);
        int cnt;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_latency"}, 64'(cnt), 64'd4);
    endtask

    task automatic check_res(input string tag, input logic [31:0] es, input logic ec);
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int stray;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;

        // Reset state, sampled mid-cycle before any clock edge.
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic add.
        send("basic", 32'h000000FF, 32'h00000001, 1'b0);
        wait_out("basic");
        check_res("basic", 32'h00000100, 1'b0);
        release_out("basic");

        // Full carry propagation via cin.
        send("fullc", 32'hFFFFFFFF, 32'h00000000, 1'b1);
        wait_out("fullc");
        check_res("fullc", 32'h00000000, 1'b1);
        release_out("fullc");

        // Mixed-byte carries; then reset while in DONE.
        send("mixed", 32'h12345678, 32'h9ABCDEF0, 1'b0);
        wait_out("mixed");
        check_res("mixed", 32'hACF13568, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_done_out_valid", 64'(out_valid), 64'd0);
        chk("rst_done_in_ready", 64'(in_ready), 64'd1);
        chk("rst_done_sum", 64'(sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Small operands with cin=1.
        send("cin1", 32'h0000000F, 32'h00000001, 1'b1);
        wait_out("cin1");
        check_res("cin1", 32'h00000011, 1'b0);
        release_out("cin1");

        // Backpressure: result held, new operands ignored while in DONE.
        send("bp", 32'h00000010, 32'h00000020, 1'b0);
        wait_out("bp");
        @(negedge clk);
        a        = 32'h00000005;
        b        = 32'h00000006;
        cin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_sum", 64'(sum), 64'h30);
            chk("bp_cout", 64'(cout), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
        chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_new_accepted", 64'(in_ready), 64'd0);
        wait_out("bp_new");
        check_res("bp_new", 32'h0000000B, 1'b0);
        release_out("bp_new");

        // Reset mid-RUN at k=2: result discarded.
        send("rstrun", 32'hAAAAAAAA, 32'h55555555, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstrun_in_ready", 64'(in_ready), 64'd1);
        chk("rstrun_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) stray++;
        end
        chk("rstrun_no_out_valid", 64'(stray), 64'd0);
        send("after_rst", 32'h00000001, 32'h00000001, 1'b0);
        wait_out("after_rst");
        check_res("after_rst", 32'h00000002, 1'b0);
        release_out("after_rst");

        // Top-byte carry-out with both MSBs set.
        send("msb", 32'h80000000, 32'h80000000, 1'b0);
        wait_out("msb");
        check_res("msb", 32'h00000000, 1'b1);
`ifdef WIDE_ADD_OVF_EN
        chk("msb_ovf", 64'(ovf), 64'd1);
`endif
        release_out("msb");

`ifdef WIDE_ADD_OVF_EN
        send("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_out("ovf_pos");
        check_res("ovf_pos", 32'h80000000, 1'b0);
        chk("ovf_pos_ovf", 64'(ovf), 64'd1);
        release_out("ovf_pos");

        send("ovf_neg", 32'hFFFFFFFF, 32'h00000001, 1'b0);
        wait_out("ovf_neg");
        check_res("ovf_neg", 32'h00000000, 1'b1);
        chk("ovf_neg_ovf", 64'(ovf), 64'd0);
        release_out("ovf_neg");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
